// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - behavioural backing-memory responder for line reads and masked writes
module mem_responder #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_TAG_BITS  = 5,
    parameter int DEPTH_LOG2    = 14,
    parameter int READ_LATENCY  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic                       mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic [1:0]                 mem_req_data_offset,
    output logic                       mem_resp_valid,
    output logic [MEM_TAG_BITS-1:0]    mem_resp_tag,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int MASK_BITS = MEM_DATA_BITS / 8;
    localparam int LINE_BITS = DEPTH_LOG2 - 2;
    localparam int CNT_W     = $clog2(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA} state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     run;
    logic [LINE_BITS-1:0]     line_q;
    logic [MEM_TAG_BITS-1:0]  tag_q;
    logic [1:0]               beat_q;
    logic [CNT_W-1:0]         lat_q;
    logic                     req_fire;
    logic                     wr_fire;
    logic                     unused_addr_bits;

    logic [MEM_DATA_BITS-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Upper line-address bits alias onto the array and are deliberately dropped
    assign unused_addr_bits = ^mem_req_addr[MEM_ADDR_BITS-1:LINE_BITS];

    // run stays low until an edge has seen reset released, so ready lags release by a cycle
    assign mem_req_ready      = reset && run && (state == IDLE);
    assign mem_req_data_ready = reset && run && (state == WR_DATA);
    assign req_fire           = mem_req_valid && mem_req_ready;
    assign wr_fire            = mem_req_data_valid && mem_req_data_ready;

    // Next-state decode for the request / burst / write-data sequence
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req_fire) state_next = mem_req_rw ? WR_DATA : RD_WAIT;
            RD_WAIT:  if (lat_q == CNT_W'(1)) state_next = RD_BURST;
            RD_BURST: if (beat_q == 2'd3) state_next = IDLE;
            WR_DATA:  if (wr_fire && (beat_q == 2'd3)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State, request latches, counters and registered response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            run            <= 1'b0;
            line_q         <= '0;
            tag_q          <= '0;
            beat_q         <= '0;
            lat_q          <= '0;
            mem_resp_valid <= 1'b0;
            mem_resp_tag   <= '0;
            mem_resp_data  <= '0;
        end else begin
            state          <= state_next;
            run            <= 1'b1;
            mem_resp_valid <= 1'b0;
            mem_resp_tag   <= '0;
            mem_resp_data  <= '0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        line_q <= mem_req_addr[LINE_BITS-1:0];
                        tag_q  <= mem_req_tag;
                        beat_q <= 2'd0;
                        lat_q  <= CNT_W'(READ_LATENCY - 1);
                    end
                end
                RD_WAIT: lat_q <= lat_q - CNT_W'(1);
                RD_BURST: begin
                    mem_resp_valid <= 1'b1;
                    mem_resp_tag   <= tag_q;
                    mem_resp_data  <= mem[{line_q, beat_q}];
                    beat_q         <= beat_q + 2'd1;
                end
                WR_DATA: if (wr_fire) beat_q <= beat_q + 2'd1;
                default: ;
            endcase
        end
    end

    // Byte-masked write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i])
                    mem[{line_q, mem_req_data_offset}][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with random and directed traffic
module tb_mem_responder;

    localparam int DB    = 128;
    localparam int AB    = 28;
    localparam int TB    = 5;
    localparam int DL    = 6;
    localparam int LAT   = 4;
    localparam int LINES = 1 << (DL - 2);

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_rw;
    logic [AB-1:0]   mem_req_addr;
    logic [TB-1:0]   mem_req_tag;
    logic            mem_req_data_valid;
    logic            mem_req_data_ready;
    logic [DB-1:0]   mem_req_data_bits;
    logic [DB/8-1:0] mem_req_data_mask;
    logic [1:0]      mem_req_data_offset;
    logic            mem_resp_valid;
    logic [TB-1:0]   mem_resp_tag;
    logic [DB-1:0]   mem_resp_data;

    mem_responder #(
        .MEM_DATA_BITS(DB), .MEM_ADDR_BITS(AB), .MEM_TAG_BITS(TB),
        .DEPTH_LOG2(DL), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_req_data_offset(mem_req_data_offset),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TB-1:0] tag;
        logic [DB-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DB-1:0] model [0:4*LINES-1];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;

    function automatic int widx(input logic [AB-1:0] addr, input int beat);
        return int'(addr % LINES) * 4 + beat;
    endfunction

    task automatic check(input string name, input logic [DB-1:0] got, input logic [DB-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every cycle either a scoreboard beat or quiet zeroed outputs
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (mem_resp_valid) begin
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat tag %h data %h at cyc %0d", mem_resp_tag, mem_resp_data, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (mem_resp_tag !== e.tag || mem_resp_data !== e.data || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL resp_beat got tag %h data %h cyc %0d want tag %h data %h cyc %0d",
                                 mem_resp_tag, mem_resp_data, cyc, e.tag, e.data, e.cyc);
                    end
                end
            end else if (mem_resp_tag !== '0 || mem_resp_data !== '0) begin
                n_bad++;
                $display("FAIL idle_outputs got tag %h data %h want 0", mem_resp_tag, mem_resp_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_ready(input string name);
        int n;
        n = 0;
        while (!mem_req_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check({name, "_req_timeout"}, 0, 1);
    endtask

    task automatic do_read(input logic [AB-1:0] addr, input logic [TB-1:0] tag,
                           input int nbeats, output int acc);
        exp_t e;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        wait_req_ready("read");
        tick();
        acc           = cyc;
        mem_req_valid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            e.tag  = tag;
            e.data = model[widx(addr, k)];
            e.cyc  = acc + LAT + k;
            sb.push_back(e);
        end
    endtask

    task automatic do_write(input logic [AB-1:0] addr, input logic [TB-1:0] tag,
                            input logic [DB-1:0] d [4], input logic [DB/8-1:0] m [4],
                            input logic [1:0] off [4], input int gap [4]);
        int n;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        wait_req_ready("write");
        tick();
        mem_req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_req_data_valid = 1'b0;
            for (int g = 0; g < gap[b]; g++) begin
                check("stall_req_ready", mem_req_ready, 0);
                tick();
            end
            mem_req_data_valid  = 1'b1;
            mem_req_data_bits   = d[b];
            mem_req_data_mask   = m[b];
            mem_req_data_offset = off[b];
            n = 0;
            while (!mem_req_data_ready && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) check("data_ready_timeout", 0, 1);
            tick();
            for (int i = 0; i < DB / 8; i++)
                if (m[b][i]) model[widx(addr, int'(off[b]))][8*i +: 8] = d[b][8*i +: 8];
            if (b < 3) check("mid_write_req_ready", mem_req_ready, 0);
        end
        mem_req_data_valid = 1'b0;
        check("post_write_req_ready", mem_req_ready, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check("scoreboard_drained", sb.size(), 0);
    endtask

    logic [DB-1:0]   wd [4];
    logic [DB/8-1:0] wm [4];
    logic [1:0]      wo [4];
    int              wg [4];
    int              acc1;
    int              acc2;

    task automatic full_beats();
        for (int b = 0; b < 4; b++) begin
            wm[b] = '1;
            wo[b] = 2'(b);
            wg[b] = 0;
        end
    endtask

    initial begin
        reset = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw = 1'b0;
        mem_req_addr = '0;
        mem_req_tag = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits = '0;
        mem_req_data_mask = '0;
        mem_req_data_offset = '0;
        repeat (3) tick();
        check("reset_req_ready", mem_req_ready, 0);
        check("reset_data_ready", mem_req_data_ready, 0);
        check("reset_resp_valid", mem_resp_valid, 0);
        check("reset_resp_tag", mem_resp_tag, 0);
        check("reset_resp_data", mem_resp_data, 0);
        reset = 1'b1;
        check("release_cycle_req_ready", mem_req_ready, 0);
        tick();
        check("after_release_req_ready", mem_req_ready, 1);
        mon_en = 1'b1;

        // Preload every line so later reads never touch unwritten words
        full_beats();
        for (int l = 0; l < LINES; l++) begin
            for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom, $urandom, $urandom};
            do_write(AB'(l), TB'(l), wd, wm, wo, wg);
        end

        // Full-mask write then read with latency/order/tag checks
        for (int b = 0; b < 4; b++) wd[b] = {32{4'(b)}};
        do_write(AB'(16), 5'd3, wd, wm, wo, wg);
        do_read(AB'(16), 5'd7, 4, acc1);
        drain();

        // Partial mask over an all-ones word
        for (int b = 0; b < 4; b++) wd[b] = '1;
        do_write(AB'(2), 5'd1, wd, wm, wo, wg);
        for (int b = 0; b < 4; b++) begin
            wd[b] = {8{16'hAABB}};
            wm[b] = '0;
        end
        wm[1] = 16'h000F;
        do_write(AB'(2), 5'd2, wd, wm, wo, wg);
        do_read(AB'(2), 5'd6, 4, acc1);
        drain();
        check("partial_mask_model", model[widx(AB'(2), 1)], {{12{8'hFF}}, 32'hAABBAABB});

        // Stalled data channel between beats 1 and 2
        full_beats();
        for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom, $urandom, $urandom};
        wg[2] = 3;
        do_write(AB'(5), 5'd8, wd, wm, wo, wg);
        do_read(AB'(5), 5'd9, 4, acc1);
        drain();

        // Back-to-back reads with valid held
        do_read(AB'(1), 5'd4, 4, acc1);
        do_read(AB'(2), 5'd5, 4, acc2);
        check("back_to_back_accept", acc2, acc1 + LAT + 4);
        drain();

        // Aliasing: line 0 and line LINES hit the same words
        full_beats();
        for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom, $urandom, $urandom};
        do_write(AB'(0), 5'd10, wd, wm, wo, wg);
        for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom, $urandom, $urandom};
        do_write(AB'(LINES), 5'd11, wd, wm, wo, wg);
        do_read(AB'(0), 5'd12, 4, acc1);
        drain();
        check("alias_beat3_model", model[widx(AB'(0), 3)], wd[3]);

        // Random traffic: masked writes with duplicate offsets and gaps, single and paired reads
        for (int op = 0; op < 40; op++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 4; b++) begin
                    wd[b] = {$urandom, $urandom, $urandom, $urandom};
                    wm[b] = 16'($urandom);
                    wo[b] = 2'($urandom_range(0, 3));
                    wg[b] = $urandom_range(0, 2);
                end
                do_write(AB'($urandom), TB'($urandom), wd, wm, wo, wg);
            end else begin
                do_read(AB'($urandom), TB'($urandom), 4, acc1);
                if ($urandom_range(0, 2) == 0) begin
                    do_read(AB'($urandom), TB'($urandom), 4, acc2);
                    check("rand_b2b_accept", acc2, acc1 + LAT + 4);
                end
            end
        end
        drain();

        // Reset during beat 1 aborts the burst; memory survives
        do_read(AB'(16), 5'd13, 2, acc1);
        while (cyc < acc1 + LAT + 1) tick();
        reset = 1'b0;
        check("in_reset_req_ready", mem_req_ready, 0);
        tick();
        check("abort_resp_valid", mem_resp_valid, 0);
        tick();
        reset = 1'b1;
        check("abort_release_req_ready", mem_req_ready, 0);
        tick();
        check("abort_after_release_req_ready", mem_req_ready, 1);
        check("abort_no_leftover", sb.size(), 0);
        do_read(AB'(16), 5'd14, 4, acc1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Behavioural backing-memory responder on the far side of the `mem_req`/`mem_resp` interface that the CPU memory subsystem drives.
- Accepts one line request at a time:
  - Reads return a 4-beat burst on `mem_resp`, tagged with the request tag, after a fixed latency.
  - Writes consume 4 masked data beats from the data channel.
- Used as the DRAM model in system testbenches and FPGA bring-up.

Parameters:
- `MEM_DATA_BITS`, 128, beat width in bits.
- `MEM_ADDR_BITS`, 28, line address width.
- `MEM_TAG_BITS`, 5, request tag width.
- `DEPTH_LOG2`, 14, log2 of beat-word count in the internal array. Must be ≥ 3.
- `READ_LATENCY`, 4, cycles from read accept to first response beat. Must be ≥ 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset. 0 = reset.
- `mem_req_valid`  in  1  request valid.
- `mem_req_ready`  out  1  responder can accept a request.
- `mem_req_rw`  in  1  1 = write, 0 = read.
- `mem_req_addr`  in  `MEM_ADDR_BITS`  line address.
- `mem_req_tag`  in  `MEM_TAG_BITS`  request tag.
- `mem_req_data_valid`  in  1  write beat valid.
- `mem_req_data_ready`  out  1  responder can accept a write beat.
- `mem_req_data_bits`  in  `MEM_DATA_BITS`  write beat data.
- `mem_req_data_mask`  in  `MEM_DATA_BITS/8`  byte enables, 1 = write byte.
- `mem_req_data_offset`  in  2  beat index within the line.
- `mem_resp_valid`  out  1  response beat valid. There is no backpressure on responses.
- `mem_resp_tag`  out  `MEM_TAG_BITS`  tag of the originating read.
- `mem_resp_data`  out  `MEM_DATA_BITS`  response beat data.

Behaviour:
- **Storage**
  - Array of 2^`DEPTH_LOG2` words, each `MEM_DATA_BITS` wide.
  - Word index = `{line_addr[DEPTH_LOG2-3:0], beat[1:0]}`. Upper address bits are ignored, so addresses alias (wrap).
  - Array contents are not cleared by reset.
- **FSM states:** IDLE, RD_WAIT, RD_BURST, WR_DATA.
- **Ready signals**
  - `mem_req_ready` = 1 only in IDLE.
  - `mem_req_data_ready` = 1 only in WR_DATA.
  - Both are decoded from registered state.
- **IDLE**
  - A request fires when `mem_req_valid & mem_req_ready` at a rising edge.
  - On fire, latch addr and tag, clear the beat counter.
  - `rw` = 0 → RD_WAIT, latency counter loaded with `READ_LATENCY-1`.
  - `rw` = 1 → WR_DATA.
- **RD_WAIT**
  - Counter decrements each cycle.
  - When it reaches 1 → RD_BURST.
  - Result: beat 0 is valid exactly `READ_LATENCY` cycles after the accept edge.
- **RD_BURST**
  - `mem_resp_valid` = 1 for exactly 4 consecutive cycles.
  - Beat k carries word `{line, k}`, for k = 0..3 in order.
  - `mem_resp_tag` = latched tag on every beat.
  - Data is read from the array as of the end of the previous cycle.
  - After beat 3 → IDLE. A new request can be accepted the cycle after beat 3.
- **WR_DATA**
  - Each fire of `mem_req_data_valid & mem_req_data_ready` writes word `{line, mem_req_data_offset}`.
  - For each byte i, the byte is written only where `mask[i]` = 1.
  - Beat counter increments per fire. After the 4th fire → IDLE.
  - Offsets are used as given; duplicate offsets overwrite.
  - Idle cycles (`data_valid` = 0) between beats are allowed and do not count.
- **Outputs when not in RD_BURST**
  - `mem_resp_valid` = 0.
  - `mem_resp_data` and `mem_resp_tag` are held at 0.
- **Ignored inputs**
  - `mem_req_valid` outside IDLE is ignored; the request is held by the initiator.
  - `data_valid` outside WR_DATA is ignored, and nothing is written.
- **Reset** (`reset` = 0 at an edge)
  - State → IDLE; all counters, latched tag and latched addr → 0.
  - Registered outputs → 0: `mem_resp_valid`, `mem_resp_tag`, `mem_resp_data`.
  - `mem_req_ready` and `mem_req_data_ready` are 0 while `reset` = 0 and return to IDLE values the cycle after release.
  - Reset mid-burst aborts the burst: no further beats, no partial completion.
  - Reset mid-write keeps beats already written.

Test Plan:
1. **Full-mask write:** write line `0x10` with beats `0x0..0` / `0x1..1` / `0x2..2` / `0x3..3`, mask all ones, tag 3. Then read line `0x10` with tag 7. → `resp_valid` high for 4 cycles starting exactly 4 cycles after the accept edge; data matches in order 0..3; tag = 7 on all beats.
2. **Partial mask:** write line `0x2` beat 1 with mask `0x000F`, data `0xAABB...` over a prior all-ones word. Read back. → beat 1 low 4 bytes = new data, upper 12 bytes = `0xFF`.
3. **Stalled data channel:** write with `data_valid` low for 3 cycles between beats 1 and 2. → `mem_req_ready` stays 0 until the 4th beat fires, then 1 the next cycle; all 4 beats are stored.
4. **Back-to-back reads:** reads to lines 1 and 2 (tags 4, 5) with `mem_req_valid` held. → second accept occurs the cycle after the first burst's beat 3; bursts are non-overlapping with correct tags.
5. **Aliasing:** write to line `0x0` and line `(1 << (DEPTH_LOG2-2))`. → both map to the same words; a read of line `0x0` returns the second write.
6. **Reset mid-burst:** assert `reset` = 0 during beat 1 of a read. → `resp_valid` = 0 from the next cycle; no remaining beats; `mem_req_ready` = 1 the cycle after release; a subsequent read returns the previously written data.
